// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus for the program loader.
// The loader takes the slave view; the byte source and memory side take the master view.
interface imem_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory,
// holding the core in reset until the whole program has been written.
//
// state | meaning
// IDLE  | waiting for start; core held; error (if any) held
// COUNT | accepting the word-count header byte
// DATA  | assembling four bytes into the next word
// WRITE | one-cycle memory write of the assembled word
// DONE  | load complete; core released
module imem_loader #(
  parameter int DEPTH = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_rst_n,
  output logic         done,
  output logic         error
);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, COUNT, DATA, WRITE, DONE} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] word_idx;
  logic [1:0]    byte_idx;
  logic [7:0]    word_cnt;
  logic [31:0]   word_buf;
  logic          in_ready;
  logic          mem_we;
  logic          accept;
  logic          bad_cnt;
  logic          last_word;

  assign accept    = bus.in_valid && in_ready;
  assign bad_cnt   = (bus.in_data == 8'd0) || (int'(bus.in_data) > DEPTH);
  assign last_word = (8'(word_idx) == word_cnt - 8'd1);

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = 32'({word_idx, 2'b00});
  assign bus.mem_wdata = word_buf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    cpu_rst_n = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = COUNT;
      end
      COUNT: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_nxt = bad_cnt ? IDLE : DATA;
      end
      DATA: begin
        in_ready = 1'b1;
        if (bus.in_valid && byte_idx == 2'd3) state_nxt = WRITE;
      end
      WRITE: begin
        mem_we    = 1'b1;
        state_nxt = last_word ? DONE : DATA;
      end
      DONE: begin
        done      = 1'b1;
        cpu_rst_n = 1'b1;
        if (start) state_nxt = COUNT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Word index holds on the last write so it never passes N-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_idx <= '0;
      byte_idx <= '0;
      word_cnt <= '0;
      word_buf <= '0;
      error    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            word_idx <= '0;
            byte_idx <= '0;
            error    <= 1'b0;
          end
        end
        COUNT: begin
          if (accept) begin
            word_cnt <= bus.in_data;
            if (bad_cnt) error <= 1'b1;
          end
        end
        DATA: begin
          if (accept) begin
            word_buf[{byte_idx, 3'b000} +: 8] <= bus.in_data;
            byte_idx <= byte_idx + 2'd1;
          end
        end
        WRITE: begin
          if (!last_word) word_idx <= word_idx + IW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule
